demux_scan_ctrl: RTL and testbench
==================================

Name: demux_scan_ctrl

Overview:
- Sequencer that drives the select and data inputs of the 8-way 1-to-8 demux (`z[7:0]`, `a`, `sel[2:0]`).
- Accepts one data bit per enabled channel over a valid/ready handshake.
- Steers each bit to its channel for a fixed dwell time, walks the channels in ascending order, skips masked channels, and reports frame completion.
- Sits directly in front of the demux, which it owns exclusively.

Parameters:
- DWELL_CYCLES, 4, cycles each channel is held driven; legal range 1..255.
- CNT_W, 8, width of the frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begins a frame; sampled in IDLE only.
- cont  input  1  continuous mode, sampled at start and at each frame boundary.
- abort  input  1  terminates the frame.
- en_mask  input  8  channel enables, bit i = demux output i.
- in_valid  input  1  data bit available.
- in_data  input  1  data bit.
- in_ready  output  1  controller accepts in_data this cycle.
- sel  output  3  demux select.
- a  output  1  demux data input.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- err  output  1  one-cycle pulse on start with en_mask == 0.
- frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: sel=0, a=0, in_ready=0, busy=0, done=0, err=0, frame_cnt=0, state=IDLE.
- Reset has priority over all inputs. Reset mid-frame returns to IDLE on the next edge; no done pulse.
- All outputs are registered.
- States: IDLE, WAIT_DATA, DWELL.
- IDLE:
  - a=0, busy=0, in_ready=0, sel holds its last value.
  - start=1 and en_mask!=0: capture mask_q=en_mask and cont_q=cont, set ptr = lowest set bit, go to WAIT_DATA.
  - start=1 and en_mask==0: err=1 for one cycle, stay in IDLE.
- WAIT_DATA:
  - busy=1, in_ready=1, a=0, sel=ptr.
  - On in_valid & in_ready: latch in_data, load dwell counter with DWELL_CYCLES-1, go to DWELL.
  - No timeout.
- DWELL:
  - busy=1, in_ready=0, sel=ptr, a=latched bit.
  - Counter decrements each cycle. At 0, ptr is advanced as follows:
    - ptr not the highest set bit of mask_q: ptr = next higher set bit, go to WAIT_DATA.
    - ptr is the highest set bit: done=1 and frame_cnt+1 (wrapping) on the following cycle.
      - cont_q=1: re-sample en_mask and cont. If en_mask!=0, ptr = lowest set bit, go to WAIT_DATA; otherwise go to IDLE with no err.
      - cont_q=0: go to IDLE.
- Latency:
  - start at cycle t gives in_ready=1 at t+1.
  - Handshake at cycle u gives sel/a valid at u+1 through u+DWELL_CYCLES.
  - in_ready re-asserts at u+DWELL_CYCLES+1.
- Mask changes mid-frame are ignored. Mask is only sampled at start or at a continuous-mode frame boundary.
- start while busy is ignored.
- abort:
  - Any non-IDLE state goes to IDLE on the next edge; a=0, busy=0, no done, frame_cnt unchanged.
  - abort has priority over handshake and dwell expiry in the same cycle.
- A single-channel mask is legal: every frame is one handshake plus one dwell.
- ptr wraps only via the frame boundary; never 7→0 within a frame.

Decomposition:
- Package demux_scan_pkg: N_CH=8, SEL_W=3, state enum {IDLE, WAIT_DATA, DWELL}.
- One sub-module, demux_next_ch: combinational finder taking mask_q and ptr, returning next higher set bit, lowest set bit, and is_last flag.
- The controller instantiates demux_next_ch and the existing demux for the integration bench.

Test Plan:
- Reset, then start with en_mask=8'hFF, cont=0, DWELL_CYCLES=4, in_valid held 1, in_data alternating 1,0,... → sel steps 0..7, each held 4 cycles with a=1,0,1,0,...; z shows one-hot on the active channel when a=1; done pulses once; frame_cnt=1; busy=0 afterwards.
- en_mask=8'b1010_0100, in_data=1 → sel visits only 2, 5, 7; channels 0,1,3,4,6 never selected; done after channel 7.
- start with en_mask=0 → err pulses one cycle, busy stays 0; start issued while busy → no effect on sequence.
- in_valid withheld 10 cycles in WAIT_DATA for channel 3 → in_ready stays 1, a=0, sel=3 throughout; data arrives → dwell starts the next cycle.
- cont=1, mask 8'h81 for 3 frames, then mask changed to 0 → frame_cnt=3, controller returns to IDLE without err; mid-frame mask change has no effect.
- abort during DWELL of channel 4 and reset during WAIT_DATA → next cycle IDLE, a=0, busy=0, no done pulse; after reset all outputs at reset values.

Source files
------------

// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the demux scan controller.
// The helper function returns the lowest set bit of a channel mask.
package demux_scan_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;

    typedef logic [SEL_W-1:0] ch_t;
    typedef logic [N_CH-1:0]  mask_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitData,
        StDwell
    } state_e;

    // Returns 0 for an empty mask; callers only use the result when the mask is non-zero.
    function automatic ch_t lowest_set(input mask_t m);
        ch_t r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = ch_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_next_ch.sv
// Combinational channel finder: from a channel mask and the current pointer, gives the
// next higher enabled channel, the lowest enabled channel and whether ptr is the last one.
module demux_next_ch
    import demux_scan_pkg::*;
(
    input  mask_t mask_i,
    input  ch_t   ptr_i,
    output ch_t   next_o,
    output ch_t   lowest_o,
    output logic  is_last_o
);

    always_comb begin
        next_o    = ptr_i;
        is_last_o = 1'b1;
        // Descending scan so the nearest higher set bit wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(ptr_i))) begin
                next_o    = ch_t'(i);
                is_last_o = 1'b0;
            end
        end
    end

    assign lowest_o = lowest_set(mask_i);

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for the 1-to-8 demux: takes one bit per enabled channel over valid/ready,
// holds it on that channel for DWELL_CYCLES, walks channels upward and counts frames.
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cont,
    input  logic                abort,
    input  logic [N_CH-1:0]     en_mask,
    input  logic                in_valid,
    input  logic                in_data,
    output logic                in_ready,
    output logic [SEL_W-1:0]    sel,
    output logic                a,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam logic [7:0] DwellLoad = 8'(DWELL_CYCLES - 1);

    state_e          state_q, state_d;
    ch_t             ptr_q, ptr_d;
    mask_t           mask_q, mask_d;
    logic            cont_q, cont_d;
    logic            bit_q, bit_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            a_q, a_d;
    ch_t             sel_q, sel_d;

    ch_t             next_ch;
    ch_t             lowest_ch;
    logic            is_last;

    demux_next_ch u_next_ch (
        .mask_i    (mask_q),
        .ptr_i     (ptr_q),
        .next_o    (next_ch),
        .lowest_o  (lowest_ch),
        .is_last_o (is_last)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mask_d      = mask_q;
        cont_d      = cont_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (en_mask != '0) begin
                        mask_d  = en_mask;
                        cont_d  = cont;
                        ptr_d   = lowest_set(en_mask);
                        state_d = StWaitData;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWaitData: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (in_valid && in_ready_q) begin
                    bit_d   = in_data;
                    cnt_d   = DwellLoad;
                    state_d = StDwell;
                end
            end
            StDwell: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!is_last) begin
                    ptr_d   = next_ch;
                    state_d = StWaitData;
                end else begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    // Continuous mode re-arms from the live mask; an empty mask ends quietly.
                    if (cont_q && (en_mask != '0)) begin
                        mask_d  = en_mask;
                        cont_d  = cont;
                        ptr_d   = lowest_set(en_mask);
                        state_d = StWaitData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        in_ready_d = (state_d == StWaitData);
        busy_d     = (state_d != StIdle);
        a_d        = (state_d == StDwell) ? bit_d : 1'b0;
        sel_d      = (state_d != StIdle) ? ptr_d : sel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            bit_q       <= 1'b0;
            cnt_q       <= 8'd0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            cont_q      <= cont_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            sel_q       <= sel_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign a         = a_q;
    assign sel       = sel_q;
    assign done      = done_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: each accepted bit queues DWELL_CYCLES expected
// (sel, a) pairs that a negedge monitor pops while the controller is dwelling.
module tb_demux_scan_ctrl;

    localparam int DWELL = 4;
    localparam int CW    = 8;

    typedef struct packed {
        logic [2:0] sel;
        logic       a;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          cont;
    logic          abort;
    logic [7:0]    en_mask;
    logic          in_valid;
    logic          in_data;
    logic          in_ready;
    logic [2:0]    sel;
    logic          a;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] frame_cnt;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;
    int   done_cnt;
    int   err_cnt;
    bit   mon_en;

    demux_scan_ctrl #(
        .DWELL_CYCLES (DWELL),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
        if (mon_en && !reset && busy) begin
            if (in_ready) begin
                check("a_wait", 32'(a), 32'd0);
            end else if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dwell_sel", 32'(sel), 32'(e.sel));
                check("dwell_a", 32'(a), 32'(e.a));
            end
        end
    end

    task automatic do_start(input logic [7:0] m, input logic c);
        @(negedge clk);
        en_mask = m;
        cont    = c;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done(input int exp_cnt, input logic exp_busy);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check("done_lat", 32'(n), 32'(DWELL + 1));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("busy_at_done", 32'(busy), 32'(exp_busy));
        check("sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    // Feeds one bit per enabled channel in ascending order; optional stall on one channel.
    task automatic feed_frame(input logic [7:0] m, input bit alt, input int stall_ch,
                              input int stall_n, input logic [7:0] mid_mask,
                              input logic [7:0] end_mask);
        int   k;
        int   n;
        logic d;
        k = 0;
        for (int ch = 0; ch < 8; ch++) begin
            if (!m[ch]) continue;
            wait_ready(n);
            if (k != 0) check("ready_lat", 32'(n), 32'(DWELL + 1));
            check("sel_wait", 32'(sel), 32'(ch));
            if (ch == stall_ch) begin
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_ready", 32'(in_ready), 32'd1);
                    check("stall_sel", 32'(sel), 32'(ch));
                    check("stall_a", 32'(a), 32'd0);
                    @(negedge clk);
                end
            end
            d        = alt ? ~k[0] : 1'b1;
            in_valid = 1'b1;
            in_data  = d;
            @(posedge clk);
            for (int j = 0; j < DWELL; j++) sb.push_back('{sel: 3'(ch), a: d});
            #1;
            in_valid = 1'b0;
            in_data  = 1'b0;
            if (k == 0) en_mask = mid_mask;
            k++;
        end
        en_mask = end_mask;
    endtask

    initial begin
        int n;
        n_vec    = 0;
        n_miss   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        abort    = 1'b0;
        en_mask  = 8'h00;
        in_valid = 1'b0;
        in_data  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Full mask, alternating data.
        do_start(8'hFF, 1'b0);
        wait_ready(n);
        check("start_lat", 32'(n), 32'd1);
        check("busy_run", 32'(busy), 32'd1);
        feed_frame(8'hFF, 1'b1, -1, 0, 8'hFF, 8'hFF);
        wait_done(1, 1'b0);
        check("done_count1", 32'(done_cnt), 32'd1);

        // Sparse mask; a start while busy must be ignored.
        do_start(8'hA4, 1'b0);
        @(negedge clk);
        en_mask = 8'hFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        en_mask = 8'hA4;
        feed_frame(8'hA4, 1'b0, -1, 0, 8'hA4, 8'hA4);
        wait_done(2, 1'b0);

        // Empty-mask start.
        @(negedge clk);
        en_mask = 8'h00;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(err), 32'd0);
        check("err_count", 32'(err_cnt), 32'd1);

        // Stall 10 cycles on channel 3.
        do_start(8'h0C, 1'b0);
        feed_frame(8'h0C, 1'b1, 3, 10, 8'h0C, 8'h0C);
        wait_done(3, 1'b0);

        // Abort in the dwell of channel 4.
        mon_en = 1'b0;
        do_start(8'h30, 1'b0);
        wait_ready(n);
        in_valid = 1'b1;
        in_data  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("abort_sel", 32'(sel), 32'd4);
        check("abort_a_pre", 32'(a), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_a", 32'(a), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        repeat (DWELL + 4) @(negedge clk);
        check("abort_nodone", 32'(done_cnt), 32'd3);
        check("abort_fcnt", 32'(frame_cnt), 32'd3);

        // Reset while waiting for data.
        do_start(8'hFF, 1'b0);
        wait_ready(n);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_ready", 32'(in_ready), 32'd0);
        check("rst2_sel", 32'(sel), 32'd0);
        check("rst2_a", 32'(a), 32'd0);
        check("rst2_fcnt", 32'(frame_cnt), 32'd0);
        check("rst2_done", 32'(done), 32'd0);
        mon_en = 1'b1;

        // Continuous mode over three frames, mid-frame mask change, then empty mask.
        do_start(8'h81, 1'b1);
        feed_frame(8'h81, 1'b1, -1, 0, 8'hFF, 8'h81);
        wait_done(1, 1'b1);
        feed_frame(8'h81, 1'b0, -1, 0, 8'h81, 8'h81);
        wait_done(2, 1'b1);
        feed_frame(8'h81, 1'b1, -1, 0, 8'h81, 8'h00);
        wait_done(3, 1'b0);
        cont = 1'b0;
        repeat (3) @(negedge clk);
        check("cont_idle", 32'(busy), 32'd0);
        check("err_total", 32'(err_cnt), 32'd1);
        check("done_total", 32'(done_cnt), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
